// File: rtl/slv_guard_pkg.sv
// Shared types and helpers for the subordinate guard reset sequencer.
package slv_guard_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISOLATE = 3'd1,
      RESET   = 3'd2,
      RELEASE = 3'd3,
      DONE    = 3'd4
   } rst_state_e;

   // Index width for n subordinates. It is never narrower than one bit, so a
   // single-subordinate build still has a usable index port.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/slv_guard_rst_ctrl.sv
// Recovery sequencer for guarded subordinates. Reset requests from the guards
// are granted one at a time in round-robin order. For each grant the
// subordinate is isolated, its reset is requested and observed, isolation is
// released, and completion is reported.
//
//  state   | meaning
//  --------+-----------------------------------------------------------------
//  IDLE    | no sequence running; arbitrates guard requests while enabled
//  ISOLATE | block traffic; wait for isolated_i or for the budget to expire
//  RESET   | drive rst_req_o; hold until status has been high long enough
//  RELEASE | reset request dropped; wait for status to fall
//  DONE    | single cycle; report completion, then back to IDLE
//
// Every output is a flop fed from the current state and the latched grant, so
// each output trails the state register by one cycle. A request reaches
// isolate_o two cycles after it is applied. iso_timeout_o is registered from
// the expiry transition, so it appears in the last cycle isolate_o is high
// without rst_req_o.
module slv_guard_rst_ctrl
   import slv_guard_pkg::*;
#(
   parameter int unsigned NumSub   = 1,
   parameter int unsigned CntWidth = 16
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             ctrl_ena_i,
   input  logic [NumSub-1:0]                guard_rst_req_i,
   output logic [NumSub-1:0]                isolate_o,
   input  logic [NumSub-1:0]                isolated_i,
   output logic [NumSub-1:0]                rst_req_o,
   input  logic [NumSub-1:0]                rst_stat_i,
   input  logic [CntWidth-1:0]              iso_budget_i,
   input  logic [CntWidth-1:0]              hold_cycles_i,
   output logic                             busy_o,
   output logic                             done_o,
   output logic [idx_width(NumSub)-1:0]     done_idx_o,
   output logic                             iso_timeout_o
);

   localparam int unsigned         IdxW    = idx_width(NumSub);
   localparam logic [CntWidth-1:0] CntMax  = '1;
   localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);
   localparam logic [IdxW-1:0]     LastIdx = IdxW'(NumSub - 1);
   localparam logic [IdxW-1:0]     IdxOne  = IdxW'(1);

   rst_state_e          state_q, state_d;
   logic [CntWidth-1:0] cnt_q, cnt_d;
   logic [IdxW-1:0]     grant_q, grant_d;
   logic [IdxW-1:0]     ptr_q, ptr_d;
   logic [NumSub-1:0]   arb_req;
   logic                arb_valid;
   logic [IdxW-1:0]     arb_idx;
   logic                timeout_hit;
   logic [NumSub-1:0]   grant_sel;

   // Round-robin pick: the lowest request at or above the pointer wins.
   // Otherwise the lowest request overall wins. Requests are only seen in IDLE
   // and only while enabled.
   always_comb begin
      arb_req   = (ctrl_ena_i && (state_q == IDLE)) ? guard_rst_req_i : '0;
      arb_valid = 1'b0;
      arb_idx   = '0;
      for (int i = 0; i < NumSub; i++) begin
         if (!arb_valid && arb_req[i] && (IdxW'(i) >= ptr_q)) begin
            arb_valid = 1'b1;
            arb_idx   = IdxW'(i);
         end
      end
      for (int i = 0; i < NumSub; i++) begin
         if (!arb_valid && arb_req[i]) begin
            arb_valid = 1'b1;
            arb_idx   = IdxW'(i);
         end
      end
   end

   // Next-state logic. ISOLATE and RESET share one saturating counter.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      grant_d     = grant_q;
      ptr_d       = ptr_q;
      timeout_hit = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (arb_valid) begin
               grant_d = arb_idx;
               ptr_d   = (arb_idx == LastIdx) ? '0 : arb_idx + IdxOne;
               state_d = ISOLATE;
            end
         end
         ISOLATE: begin
            if (isolated_i[grant_q]) begin
               state_d = RESET;
               cnt_d   = '0;
            end else if ((iso_budget_i != '0) && (cnt_q == iso_budget_i - CntOne)) begin
               timeout_hit = 1'b1;
               state_d     = RESET;
               cnt_d       = '0;
            end else begin
               cnt_d = (cnt_q == CntMax) ? CntMax : cnt_q + CntOne;
            end
         end
         RESET: begin
            if (rst_stat_i[grant_q]) begin
               if (cnt_q >= hold_cycles_i) begin
                  state_d = RELEASE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = (cnt_q == CntMax) ? CntMax : cnt_q + CntOne;
               end
            end else begin
               // A status drop before the hold is met restarts the count.
               cnt_d = '0;
            end
         end
         RELEASE: begin
            cnt_d = '0;
            if (!rst_stat_i[grant_q]) state_d = DONE;
         end
         DONE: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // One-hot select for the latched grant.
   always_comb begin
      grant_sel          = '0;
      grant_sel[grant_q] = 1'b1;
   end

   // State, counter, grant and round-robin pointer registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   // Registered outputs, decoded from the current state and the grant.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         isolate_o     <= '0;
         rst_req_o     <= '0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
         done_idx_o    <= '0;
         iso_timeout_o <= 1'b0;
      end else begin
         isolate_o     <= (state_q inside {ISOLATE, RESET, RELEASE}) ? grant_sel : '0;
         rst_req_o     <= (state_q == RESET) ? grant_sel : '0;
         busy_o        <= (state_q != IDLE);
         done_o        <= (state_q == DONE);
         iso_timeout_o <= timeout_hit;
         if (state_q == DONE) done_idx_o <= grant_q;
      end
   end

   a_iso_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
      $onehot0(isolate_o));
   a_rst_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
      $onehot0(rst_req_o));
   a_rst_implies_iso: assert property (@(posedge clk_i) disable iff (!rst_ni)
      ((rst_req_o & ~isolate_o) == '0));

endmodule

// File: tb/tb_slv_guard_rst_ctrl.sv
// Directed bench for the guard reset sequencer, built with four subordinates.
module tb_slv_guard_rst_ctrl;

   localparam int N  = 4;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ena;
   logic [N-1:0]  guard;
   logic [N-1:0]  iso_out;
   logic [N-1:0]  isolated;
   logic [N-1:0]  rst_req;
   logic [N-1:0]  stat;
   logic [CW-1:0] budget;
   logic [CW-1:0] hold;
   logic          busy;
   logic          done;
   logic [1:0]    done_idx;
   logic          iso_to;

   int n_vec = 0;
   int n_err = 0;

   slv_guard_rst_ctrl #(.NumSub(N), .CntWidth(CW)) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .ctrl_ena_i      (ena),
      .guard_rst_req_i (guard),
      .isolate_o       (iso_out),
      .isolated_i      (isolated),
      .rst_req_o       (rst_req),
      .rst_stat_i      (stat),
      .iso_budget_i    (budget),
      .hold_cycles_i   (hold),
      .busy_o          (busy),
      .done_o          (done),
      .done_idx_o      (done_idx),
      .iso_timeout_o   (iso_to)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reset status follows rst_req_o, as a simple SoC reset controller would.
   // Runs until done_o is seen or the cycle budget expires.
   task automatic finish_seq(input string tag, input logic [31:0] exp_idx);
      logic [31:0] seen;
      logic        got;
      seen = 32'hdead;
      got  = 1'b0;
      for (int c = 0; c < 100; c++) begin
         if (!got) begin
            stat = rst_req;
            tick();
            if (done) begin
               seen = 32'(done_idx);
               got  = 1'b1;
            end
         end
      end
      stat = '0;
      chk(tag, seen, exp_idx);
   endtask

   task automatic wait_rst_req(input string tag, input logic [31:0] exp);
      logic got;
      got = 1'b0;
      for (int c = 0; c < 50; c++) begin
         if (!got) begin
            tick();
            if (rst_req != '0) got = 1'b1;
         end
      end
      chk(tag, 32'(rst_req), exp);
   endtask

   initial begin
      logic to_seen;
      rst_n = 1'b1; ena = 1'b0; guard = '0; isolated = '0; stat = '0;
      budget = '0; hold = '0;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_isolate", 32'(iso_out), 0);
      chk("rst_rst_req", 32'(rst_req), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_done_idx", 32'(done_idx), 0);
      chk("rst_timeout", 32'(iso_to), 0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Fairness: all four requests held; completions come out 0,1,2,3,0.
      ena = 1'b1; guard = 4'b1111; isolated = 4'b1111; hold = 0; budget = 0;
      finish_seq("rr_0", 0);
      finish_seq("rr_1", 1);
      finish_seq("rr_2", 2);
      finish_seq("rr_3", 3);
      finish_seq("rr_4", 0);
      guard = '0;
      tick(); tick(); tick();
      chk("rr_idle_busy", 32'(busy), 0);

      // Single request with hold = 4 (pointer is 1, so the grant wraps to 0).
      isolated = '0; stat = '0; hold = 4; guard = 4'b0001;
      tick();
      chk("single_lat1", 32'(iso_out), 0);
      tick();
      chk("single_iso", 32'(iso_out), 4'b0001);
      chk("single_busy", 32'(busy), 1);
      guard = '0;
      tick(); tick();
      isolated = 4'b0001;
      tick();
      chk("single_no_rst_yet", 32'(rst_req), 0);
      tick();
      chk("single_rst_req", 32'(rst_req), 4'b0001);
      tick();
      stat = 4'b0001;
      tick(); tick(); tick(); tick();
      chk("single_hold_a", 32'(rst_req), 4'b0001);
      tick();
      chk("single_hold_b", 32'(rst_req), 4'b0001);
      tick();
      chk("single_rel_rst", 32'(rst_req), 0);
      chk("single_rel_iso", 32'(iso_out), 4'b0001);
      stat = '0;
      tick();
      chk("single_not_done", 32'(done), 0);
      tick();
      chk("single_done", 32'(done), 1);
      chk("single_done_idx", 32'(done_idx), 0);
      chk("single_done_iso", 32'(iso_out), 0);
      tick();
      chk("single_busy_low", 32'(busy), 0);
      chk("single_done_low", 32'(done), 0);
      isolated = '0;

      // Isolation timeout with a budget of 8 cycles (grant 2).
      budget = 8; hold = 0; guard = 4'b0100;
      tick();
      guard = '0;
      for (int k = 0; k < 7; k++) tick();
      chk("to_pre_pulse", 32'(iso_to), 0);
      chk("to_pre_iso", 32'(iso_out), 4'b0100);
      tick();
      chk("to_pulse", 32'(iso_to), 1);
      chk("to_pulse_rst", 32'(rst_req), 0);
      tick();
      chk("to_pulse_end", 32'(iso_to), 0);
      chk("to_rst_req", 32'(rst_req), 4'b0100);
      finish_seq("to_done", 2);

      // A budget of zero waits indefinitely (grant 3).
      budget = 0; guard = 4'b1000;
      tick();
      guard = '0;
      to_seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         tick();
         to_seen = to_seen | iso_to;
      end
      chk("nobudget_pulse", 32'(to_seen), 0);
      chk("nobudget_iso", 32'(iso_out), 4'b1000);
      chk("nobudget_rst", 32'(rst_req), 0);
      isolated = 4'b1000;
      finish_seq("nobudget_done", 3);
      isolated = '0;

      // Status glitch with hold = 3: the dropout restarts the hold count.
      isolated = 4'b0001; hold = 3; guard = 4'b0001;
      tick();
      guard = '0;
      tick(); tick();
      chk("glitch_rst_req", 32'(rst_req), 4'b0001);
      stat = 4'b0001;
      tick(); tick();
      stat = '0;
      tick();
      stat = 4'b0001;
      tick(); tick(); tick();
      chk("glitch_hold_a", 32'(rst_req), 4'b0001);
      tick();
      chk("glitch_hold_b", 32'(rst_req), 4'b0001);
      tick();
      chk("glitch_release", 32'(rst_req), 0);
      stat = '0;
      finish_seq("glitch_done", 0);

      // Disabling during RESET lets the sequence finish but blocks new grants.
      isolated = 4'b1111; hold = 2; guard = 4'b0010;
      wait_rst_req("dis_rst_req", 4'b0010);
      ena = 1'b0; guard = 4'b1111;
      finish_seq("dis_done", 1);
      for (int k = 0; k < 10; k++) tick();
      chk("dis_no_busy", 32'(busy), 0);
      chk("dis_no_iso", 32'(iso_out), 0);
      ena = 1'b1;
      tick(); tick();
      chk("rr_resume", 32'(iso_out), 4'b0100);

      // Asynchronous reset in the middle of RESET.
      wait_rst_req("mid_rst_req", 4'b0100);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_iso_drop", 32'(iso_out), 0);
      chk("mid_rst_drop", 32'(rst_req), 0);
      chk("mid_busy_drop", 32'(busy), 0);
      guard = '0; stat = '0;
      tick(); tick();
      rst_n = 1'b1;
      guard = 4'b1010;
      tick();
      chk("post_rst_idle", 32'(iso_out), 0);
      tick();
      chk("post_rst_ptr0", 32'(iso_out), 4'b0010);
      guard = '0;
      finish_seq("post_rst_done", 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
